// File: rtl/tile_skew_feeder_pkg.sv
// Shared configuration for the tile skew feeder: default geometry, phase-counter
// sizing, tile element indexing and the streaming FSM encoding.
package tile_skew_feeder_pkg;
  localparam int S2P_SIZE   = 4;
  localparam int DATA_WIDTH = 8;

  // Phase runs 0..2*S2P-2; keep at least one bit so S2P=1 still has a counter.
  function automatic int phase_w(input int s2p);
    return (2 * s2p - 1 > 1) ? $clog2(2 * s2p - 1) : 1;
  endfunction

  function automatic int elem_idx(input int r, input int c, input int s2p);
    return r * s2p + c;
  endfunction

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} feed_state_e;
endpackage

// File: rtl/tile_pingpong_buf.sv
// Two-entry ping-pong store for tensor/weight tile pairs with drop-on-full
// overflow tracking and a same-cycle capture/release rule.
module tile_pingpong_buf
  import tile_skew_feeder_pkg::*;
#(
  parameter int S2P = S2P_SIZE,
  parameter int DW  = DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [S2P*S2P*DW-1:0]  wr_tensor,
  input  logic [S2P*S2P*DW-1:0]  wr_weight,
  input  logic                   wr_k_last,
  input  logic                   rel,
  output logic [1:0]             count,
  output logic [S2P*S2P*DW-1:0]  cur_tensor,
  output logic [S2P*S2P*DW-1:0]  cur_weight,
  output logic                   cur_k_last,
  output logic [S2P*S2P*DW-1:0]  nxt_tensor,
  output logic [S2P*S2P*DW-1:0]  nxt_weight,
  output logic                   nxt_k_last,
  output logic                   full,
  output logic                   overflow
);
  logic                  wr_ptr, rd_ptr;
  logic [S2P*S2P*DW-1:0] tensor_q [2];
  logic [S2P*S2P*DW-1:0] weight_q [2];
  logic [1:0]            klast_q;
  logic                  accept, drop, byp;
  logic [1:0]            count_n;

  // A release in the same cycle frees a slot, so a full buffer can still accept.
  assign accept = wr_en && ((count != 2'd2) || rel);
  assign drop   = wr_en && (count == 2'd2) && !rel;

  always_comb begin
    count_n = count;
    case ({accept, rel})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (rel)    rd_ptr <= ~rd_ptr;
      count <= count_n;
      full  <= (count_n == 2'd2);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tensor_q[wr_ptr] <= wr_tensor;
      weight_q[wr_ptr] <= wr_weight;
      klast_q[wr_ptr]  <= wr_k_last;
    end
  end

  assign cur_tensor = tensor_q[rd_ptr];
  assign cur_weight = weight_q[rd_ptr];
  assign cur_k_last = klast_q[rd_ptr];

  // Next tile may be landing this very cycle; forward it so there is no bubble.
  assign byp        = accept && (wr_ptr != rd_ptr);
  assign nxt_tensor = byp ? wr_tensor : tensor_q[~rd_ptr];
  assign nxt_weight = byp ? wr_weight : weight_q[~rd_ptr];
  assign nxt_k_last = byp ? wr_k_last : klast_q[~rd_ptr];
endmodule

// File: rtl/tile_skew_feeder.sv
// Streams buffered tile pairs diagonally skewed into an S2PxS2P systolic array,
// one registered beat per phase, holding under back-pressure.
module tile_skew_feeder
  import tile_skew_feeder_pkg::*;
#(
  parameter int S2P = S2P_SIZE,
  parameter int DW  = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tile_valid,
  input  logic [S2P*S2P*DW-1:0] i_matrix_tensor,
  input  logic [S2P*S2P*DW-1:0] i_matrix_weight,
  input  logic                  i_k_last,
  input  logic                  i_array_ready,
  output logic [S2P*DW-1:0]     o_a_data,
  output logic [S2P*DW-1:0]     o_b_data,
  output logic [S2P-1:0]        o_lane_valid,
  output logic                  o_beat_valid,
  output logic                  o_first,
  output logic                  o_last,
  output logic                  o_k_last,
  output logic                  o_tile_done,
  output logic                  o_full,
  output logic                  o_overflow
);
  localparam int            PW      = phase_w(S2P);
  localparam logic [PW-1:0] LAST_PH = PW'(2 * S2P - 2);

  feed_state_e state, state_n;
  logic [PW-1:0] phase, ld_phase;
  logic          load, sel_nxt, rel, clear;

  logic [1:0]            count;
  logic [S2P*S2P*DW-1:0] cur_t, cur_w, nxt_t, nxt_w, src_t, src_w;
  logic                  cur_kl, nxt_kl, src_kl;

  logic [S2P-1:0][DW-1:0] a_q, b_q, a_n, b_n;
  logic [S2P-1:0]         lv_q, lv_n;
  logic                   beat_q, first_q, last_q, kl_q;

  tile_pingpong_buf #(.S2P(S2P), .DW(DW)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (i_tile_valid),
    .wr_tensor  (i_matrix_tensor),
    .wr_weight  (i_matrix_weight),
    .wr_k_last  (i_k_last),
    .rel        (rel),
    .count      (count),
    .cur_tensor (cur_t),
    .cur_weight (cur_w),
    .cur_k_last (cur_kl),
    .nxt_tensor (nxt_t),
    .nxt_weight (nxt_w),
    .nxt_k_last (nxt_kl),
    .full       (o_full),
    .overflow   (o_overflow)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    sel_nxt  = 1'b0;
    ld_phase = '0;
    rel      = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          load    = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (i_array_ready) begin
          if (phase == LAST_PH) begin
            rel = 1'b1;
            // Another tile remains after this release: start it without a gap.
            if ((count == 2'd2) || i_tile_valid) begin
              load    = 1'b1;
              sel_nxt = 1'b1;
            end else begin
              clear   = 1'b1;
              state_n = IDLE;
            end
          end else begin
            load     = 1'b1;
            ld_phase = phase + PW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign src_t  = sel_nxt ? nxt_t  : cur_t;
  assign src_w  = sel_nxt ? nxt_w  : cur_w;
  assign src_kl = sel_nxt ? nxt_kl : cur_kl;

  // Lane i carries element k of its row when phase == i + k.
  always_comb begin
    a_n  = '0;
    b_n  = '0;
    lv_n = '0;
    for (int i = 0; i < S2P; i++) begin
      for (int k = 0; k < S2P; k++) begin
        if (ld_phase == PW'(i + k)) begin
          a_n[i]  = src_t[elem_idx(i, k, S2P)*DW +: DW];
          b_n[i]  = src_w[elem_idx(i, k, S2P)*DW +: DW];
          lv_n[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lv_q    <= '0;
      beat_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      kl_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        phase   <= ld_phase;
        a_q     <= a_n;
        b_q     <= b_n;
        lv_q    <= lv_n;
        beat_q  <= 1'b1;
        first_q <= (ld_phase == '0);
        last_q  <= (ld_phase == LAST_PH);
        kl_q    <= src_kl;
      end else if (clear) begin
        phase   <= '0;
        a_q     <= '0;
        b_q     <= '0;
        lv_q    <= '0;
        beat_q  <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
        kl_q    <= 1'b0;
      end
    end
  end

  assign o_a_data     = a_q;
  assign o_b_data     = b_q;
  assign o_lane_valid = lv_q;
  assign o_beat_valid = beat_q;
  assign o_first      = first_q;
  assign o_last       = last_q;
  assign o_k_last     = kl_q;
  assign o_tile_done  = beat_q & last_q & i_array_ready;
endmodule

// File: tb/tb_tile_skew_feeder.sv
// Randomized bench for tile_skew_feeder against a per-phase skew model of the tile stream.
module tb_tile_skew_feeder;
  localparam int S = 4;
  localparam int D = 8;
  localparam int N = S * S * D;
  localparam int P = 2 * S - 1;

  typedef struct {
    logic [N-1:0] t;
    logic [N-1:0] w;
    logic         kl;
  } tile_s;

  typedef struct packed {
    logic [S*D-1:0] a;
    logic [S*D-1:0] b;
    logic [S-1:0]   lv;
    logic           first;
    logic           last;
    logic           kl;
    logic           done;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_tile_valid, i_k_last, i_array_ready;
  logic [N-1:0]   i_matrix_tensor, i_matrix_weight;
  logic [S*D-1:0] o_a_data, o_b_data;
  logic [S-1:0]   o_lane_valid;
  logic           o_beat_valid, o_first, o_last, o_k_last, o_tile_done, o_full, o_overflow;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  beat_t obs[$];
  int    obs_cyc[$];
  beat_t exp_q[$];

  tile_skew_feeder #(.S2P(S), .DW(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_tile_valid    (i_tile_valid),
    .i_matrix_tensor (i_matrix_tensor),
    .i_matrix_weight (i_matrix_weight),
    .i_k_last        (i_k_last),
    .i_array_ready   (i_array_ready),
    .o_a_data        (o_a_data),
    .o_b_data        (o_b_data),
    .o_lane_valid    (o_lane_valid),
    .o_beat_valid    (o_beat_valid),
    .o_first         (o_first),
    .o_last          (o_last),
    .o_k_last        (o_k_last),
    .o_tile_done     (o_tile_done),
    .o_full          (o_full),
    .o_overflow      (o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && o_beat_valid && i_array_ready) begin
      obs.push_back('{o_a_data, o_b_data, o_lane_valid, o_first, o_last, o_k_last, o_tile_done});
      obs_cyc.push_back(cyc);
    end
  end

  function automatic beat_t exp_beat(tile_s tl, int p);
    beat_t e;
    e = '0;
    for (int i = 0; i < S; i++) begin
      int k;
      k = p - i;
      if (k >= 0 && k < S) begin
        e.a[i*D +: D] = tl.t[(i*S+k)*D +: D];
        e.b[i*D +: D] = tl.w[(i*S+k)*D +: D];
        e.lv[i]       = 1'b1;
      end
    end
    e.first = (p == 0);
    e.last  = (p == P - 1);
    e.kl    = tl.kl;
    e.done  = e.last;
    return e;
  endfunction

  function automatic tile_s rand_tile();
    tile_s t;
    for (int i = 0; i < S * S; i++) begin
      t.t[i*D +: D] = D'($urandom_range(0, 255));
      t.w[i*D +: D] = D'($urandom_range(0, 255));
    end
    t.kl = 1'($urandom_range(0, 1));
    return t;
  endfunction

  task automatic add_tile(input tile_s t);
    for (int p = 0; p < P; p++) exp_q.push_back(exp_beat(t, p));
  endtask

  task automatic pulse(input tile_s t);
    @(posedge clk); #1;
    i_tile_valid    = 1'b1;
    i_matrix_tensor = t.t;
    i_matrix_weight = t.w;
    i_k_last        = t.kl;
    @(posedge clk); #1;
    i_tile_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_tile_valid = 1'b0;
    i_k_last = 1'b0;
    i_array_ready = 1'b0;
    i_matrix_tensor = '0;
    i_matrix_weight = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_tile_valid = 1'b0;
    i_array_ready = 1'b1;
    #3;
    total++;
    if ({o_a_data, o_b_data, o_lane_valid, o_beat_valid, o_first, o_last, o_k_last,
         o_tile_done, o_full, o_overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h b=%h v=%b bv=%b want all zero",
               o_a_data, o_b_data, o_lane_valid, o_beat_valid);
    end
  endtask

  task automatic test_single();
    tile_s t;
    do_reset();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        t.t[(r*S+c)*D +: D] = D'(16 * r + c);
        t.w[(r*S+c)*D +: D] = D'(8'h80 + 16 * r + c);
      end
    t.kl = 1'b0;
    i_array_ready = 1'b1;
    @(posedge clk); #1;
    i_tile_valid = 1'b1; i_matrix_tensor = t.t; i_matrix_weight = t.w; i_k_last = t.kl;
    @(posedge clk); #1;
    i_tile_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_beat_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got valid=%b want 0", o_beat_valid); end
    @(negedge clk);
    total++;
    if ({o_beat_valid, o_first} !== 2'b11) begin
      bad++; $display("FAIL latency_first: got valid,first=%b%b want 11", o_beat_valid, o_first);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    add_tile(t);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++; $display("FAIL single_count: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++; $display("FAIL single_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    if (obs.size() >= 7) begin
      total++;
      if (obs[0].lv !== 4'b0001 || obs[0].a !== 32'h0) begin
        bad++; $display("FAIL single_ph0: got lv=%b a=%h want 0001 00000000", obs[0].lv, obs[0].a);
      end
      total++;
      if (obs[3].a !== 32'h30211203 || obs[3].lv !== 4'b1111) begin
        bad++; $display("FAIL single_ph3: got a=%h lv=%b want 30211203 1111", obs[3].a, obs[3].lv);
      end
      total++;
      if (obs[6].a !== 32'h33000000 || obs[6].b !== 32'hB3000000 || obs[6].lv !== 4'b1000 ||
          obs[6].done !== 1'b1) begin
        bad++; $display("FAIL single_ph6: got a=%h b=%h lv=%b done=%b want 33000000 B3000000 1000 1",
                        obs[6].a, obs[6].b, obs[6].lv, obs[6].done);
      end
    end
    total++;
    if ({o_full, o_overflow, o_beat_valid} !== 3'b000) begin
      bad++; $display("FAIL single_idle: got full,ovf,valid=%b%b%b want 000", o_full, o_overflow, o_beat_valid);
    end
  endtask

  task automatic test_overflow();
    tile_s t0, t1, t2;
    do_reset();
    t0 = rand_tile(); t1 = rand_tile(); t2 = rand_tile();
    pulse(t0); pulse(t1); pulse(t2);
    @(negedge clk);
    total++;
    if ({o_full, o_overflow} !== 2'b11 || obs.size() != 0) begin
      bad++; $display("FAIL ovf_state: got full,ovf=%b%b beats=%0d want 11 0", o_full, o_overflow, obs.size());
    end
    add_tile(t0); add_tile(t1);
    @(posedge clk); #1 i_array_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++; $display("FAIL ovf_count: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovf_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    if (obs.size() >= 14) begin
      total++;
      if (obs_cyc[13] - obs_cyc[0] != 13) begin
        bad++; $display("FAIL ovf_bubble: got span %0d cycles want 13", obs_cyc[13] - obs_cyc[0]);
      end
    end
    total++;
    if ({o_full, o_overflow} !== 2'b01) begin
      bad++; $display("FAIL ovf_sticky: got full,ovf=%b%b want 01", o_full, o_overflow);
    end
  endtask

  task automatic test_ready_toggle();
    tile_s t;
    beat_t e, got;
    int nacc;
    do_reset();
    t = rand_tile();
    pulse(t);
    nacc = 0;
    for (int c = 0; c < 40 && nacc < P; c++) begin
      @(posedge clk); #1 i_array_ready = c[0];
      @(negedge clk);
      if (o_beat_valid) begin
        e = exp_beat(t, nacc);
        e.done = e.done & i_array_ready;
        got = '{o_a_data, o_b_data, o_lane_valid, o_first, o_last, o_k_last, o_tile_done};
        total++;
        if (got !== e) begin
          bad++; $display("FAIL toggle_cyc%0d: got %h want %h (ready=%b)", c, got, e, i_array_ready);
        end
        if (i_array_ready) nacc++;
      end
    end
    total++;
    if (nacc != P) begin bad++; $display("FAIL toggle_count: got %0d accepted want %0d", nacc, P); end
  endtask

  task automatic test_coincident();
    tile_s t0, t1, t2;
    bit    hit;
    do_reset();
    t0 = rand_tile(); t1 = rand_tile(); t2 = rand_tile();
    pulse(t0); pulse(t1);
    @(posedge clk); #1 i_array_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (o_beat_valid && o_last) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL coin_timeout: got no final beat want one within 30 cycles"); end
    i_tile_valid = 1'b1; i_matrix_tensor = t2.t; i_matrix_weight = t2.w; i_k_last = t2.kl;
    @(posedge clk); #1 i_tile_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({o_full, o_overflow} !== 2'b10) begin
      bad++; $display("FAIL coin_state: got full,ovf=%b%b want 10", o_full, o_overflow);
    end
    add_tile(t0); add_tile(t1); add_tile(t2);
    repeat (25) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++; $display("FAIL coin_count: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++; $display("FAIL coin_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
    total++;
    if (o_overflow !== 1'b0) begin bad++; $display("FAIL coin_ovf: got %b want 0", o_overflow); end
  endtask

  task automatic test_k_last();
    tile_s ta, tb;
    do_reset();
    ta = rand_tile(); ta.kl = 1'b1;
    tb = rand_tile(); tb.kl = 1'b0;
    i_array_ready = 1'b1;
    pulse(ta); pulse(tb);
    add_tile(ta); add_tile(tb);
    repeat (25) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++; $display("FAIL klast_count: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++; $display("FAIL klast_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    tile_s ta, tb, tc;
    bit    hit;
    do_reset();
    ta = rand_tile(); tb = rand_tile(); tc = rand_tile();
    i_array_ready = 1'b1;
    pulse(ta); pulse(tb);
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (o_beat_valid && o_lane_valid == 4'b1111) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rstmid_timeout: got no phase-3 beat want one"); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_a_data, o_b_data, o_lane_valid, o_beat_valid, o_first, o_last, o_k_last,
         o_tile_done, o_full, o_overflow} !== '0) begin
      bad++; $display("FAIL rstmid_outputs: got a=%h b=%h v=%b bv=%b full=%b want all zero",
                      o_a_data, o_b_data, o_lane_valid, o_beat_valid, o_full);
    end
    @(posedge clk); #1 rst = 1'b0;
    obs.delete(); obs_cyc.delete(); exp_q.delete();
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs.size() != 0 || o_beat_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet: got %0d beats valid=%b want 0 0", obs.size(), o_beat_valid);
    end
    pulse(tc);
    add_tile(tc);
    repeat (12) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs.size() != exp_q.size()) begin
      bad++; $display("FAIL rstmid_count: got %0d beats want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++; $display("FAIL rstmid_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_ready_toggle();
    test_coincident();
    test_k_last();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
